score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_pkg.sv | 17 +
 rtl/bcd_digit.sv | 40 ++++
 rtl/score_keeper.sv | 132 +++++++++++++
 3 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types for the score keeper: FSM states, BCD digit/score types and the
// default display-refresh divider.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OVER
    } state_e;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [3:0] score_t;

    localparam int   REFRESH_DIV_DEF = 50000;
    localparam bcd_t BCD_MAX         = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD decade: clear, increment with ripple carry-out, hold when saturated.
// Next value is exported so the parent can register a display copy in the same cycle.
module bcd_digit
    import score_keeper_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    input  logic sat_i,
    output bcd_t dig_o,
    output bcd_t dig_nxt_o,
    output logic carry_o
);

    bcd_t dig_q;
    bcd_t dig_d;

    always_comb begin
        dig_d = dig_q;
        if (clr_i) begin
            dig_d = '0;
        end else if (inc_i && !sat_i) begin
            dig_d = (dig_q == BCD_MAX) ? '0 : dig_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

    assign carry_o   = inc_i && (dig_q == BCD_MAX);
    assign dig_o     = dig_q;
    assign dig_nxt_o = dig_d;

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: edge-detected controls, 4-digit BCD score with saturation, high score,
// registered display select (one cycle after a point edge) and a free-running refresh clock.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       point,
    input  logic       game_over,
    input  logic       show_high,
    output logic [3:0] points_3,
    output logic [3:0] points_2,
    output logic [3:0] points_1,
    output logic [3:0] points_0,
    output logic       sevenseg_clk,
    output logic       new_high
);

    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic start_q, point_q, go_q, armed_q;
    logic start_edge, point_edge, go_edge;

    state_e state_q, state_d;
    logic   over_first_q, over_first_d;
    logic   score_clr, run_inc, beat;
    logic   [4:0] carry;
    score_t score_q, score_d, high_q, high_d, points_q, points_d;
    logic   new_high_q, new_high_d;
    logic   [CW-1:0] div_q, div_d;
    logic   seg_q, seg_d;

    // armed_q keeps the first post-reset sample from reading a held-high input as an edge
    assign start_edge = armed_q & start & ~start_q;
    assign point_edge = armed_q & point & ~point_q;
    assign go_edge    = armed_q & game_over & ~go_q;

    assign carry[0] = run_inc;

    // carry[4] fires only when an increment would roll 9999 over, so it doubles as saturate
    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit u_dig (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (score_clr),
            .inc_i    (carry[i]),
            .sat_i    (carry[4]),
            .dig_o    (score_q[i]),
            .dig_nxt_o(score_d[i]),
            .carry_o  (carry[i+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        score_clr = 1'b0;
        run_inc   = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d   = ST_RUN;
                    score_clr = 1'b1;
                end
            end
            ST_RUN: begin
                run_inc = point_edge;
                if (go_edge) begin
                    state_d = ST_OVER;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        over_first_d = (state_q == ST_RUN) && (state_d == ST_OVER);

        beat   = over_first_q && (score_q > high_q);
        high_d = beat ? score_q : high_q;

        new_high_d = new_high_q;
        if (beat) begin
            new_high_d = 1'b1;
        end
        if (score_clr) begin
            new_high_d = 1'b0;
        end

        points_d = show_high ? high_d : score_d;

        div_d = (div_q == DIV_LAST) ? '0 : div_q + CW'(1);
        seg_d = (div_q == DIV_LAST) ? ~seg_q : seg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            point_q      <= 1'b0;
            go_q         <= 1'b0;
            armed_q      <= 1'b0;
            state_q      <= ST_IDLE;
            over_first_q <= 1'b0;
            high_q       <= '0;
            new_high_q   <= 1'b0;
            points_q     <= '0;
            div_q        <= '0;
            seg_q        <= 1'b0;
        end else begin
            start_q      <= start;
            point_q      <= point;
            go_q         <= game_over;
            armed_q      <= 1'b1;
            state_q      <= state_d;
            over_first_q <= over_first_d;
            high_q       <= high_d;
            new_high_q   <= new_high_d;
            points_q     <= points_d;
            div_q        <= div_d;
            seg_q        <= seg_d;
        end
    end

    assign points_3     = points_q[3];
    assign points_2     = points_q[2];
    assign points_1     = points_q[1];
    assign points_0     = points_q[0];
    assign sevenseg_clk = seg_q;
    assign new_high     = new_high_q;

endmodule
